// File: rtl/ksg_pkg.sv
// Shared definitions for the ChaCha keystream serializer: default geometry
// and the serializer state encoding (also used by the bench).
package ksg_pkg;

  localparam int unsigned KSG_WORD_SIZE  = 32;
  localparam int unsigned KSG_BLOCK_BITS = 512;
  localparam int unsigned KSG_NUM_WORDS  = KSG_BLOCK_BITS / KSG_WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } ser_state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// Keystream block holding register: parallel load of a whole block, then
// shift right by one word per emitted word so the current word is always
// in the low bits.
module ser_shift_reg
  import ksg_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = KSG_WORD_SIZE,
  parameter int unsigned BLOCK_BITS = KSG_BLOCK_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [BLOCK_BITS-1:0] i_data,
  output logic [WORD_SIZE-1:0]  o_word
);

  logic [BLOCK_BITS-1:0] r_shreg;

  // Load has priority over shift; both are mutually exclusive in practice.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= r_shreg >> WORD_SIZE;
    end
  end

  assign o_word = r_shreg[WORD_SIZE-1:0];

endmodule

// File: rtl/ksg_serializer.sv
// ChaCha keystream serializer: accepts one keystream block and emits it as
// NUM_WORDS words (word 0 first), pulses done_out after the last word and
// counts completed blocks.
// Optional build macro KSG_SERIALIZER_XOR_EN: adds a plaintext word stream
// (pt_in/pt_valid/pt_ready) that is XORed with the keystream on output.
module ksg_serializer
  import ksg_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = KSG_WORD_SIZE,
  parameter int unsigned BLOCK_BITS = KSG_BLOCK_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [BLOCK_BITS-1:0] key_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
`ifdef KSG_SERIALIZER_XOR_EN
  input  logic [WORD_SIZE-1:0]  pt_in,
  input  logic                  pt_valid,
  output logic                  pt_ready,
`endif
  output logic                  done_out,
  output logic [31:0]           block_count
);

  localparam int unsigned NUM_WORDS = BLOCK_BITS / WORD_SIZE;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  if ((BLOCK_BITS % WORD_SIZE) != 0) begin : g_geom_check
    $error("BLOCK_BITS must be a multiple of WORD_SIZE");
  end

  ser_state_e           r_state;
  ser_state_e           w_state_next;
  logic [IDX_W-1:0]     r_index;
  logic [31:0]          r_block_count;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_take;
  logic [WORD_SIZE-1:0] w_word;

  ser_shift_reg #(
    .WORD_SIZE  (WORD_SIZE),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_shreg (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (key_in),
    .o_word  (w_word)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; the last word moves to DONE without
  // shifting so the register keeps the final word until the next load.
  always_comb begin
    w_state_next = r_state;
    ready_in     = 1'b0;
    valid_out    = 1'b0;
    done_out     = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_take       = 1'b0;
    data_out     = w_word;
`ifdef KSG_SERIALIZER_XOR_EN
    pt_ready     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) begin
          w_load       = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
`ifdef KSG_SERIALIZER_XOR_EN
        valid_out = pt_valid;
        pt_ready  = ready_out;
        data_out  = w_word ^ pt_in;
        w_take    = pt_valid && ready_out;
`else
        valid_out = 1'b1;
        w_take    = ready_out;
`endif
        if (w_take) begin
          if (r_index == LAST_IDX) begin
            w_state_next = DONE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      DONE: begin
        done_out     = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Word index within the current block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_index <= '0;
    end else if (w_load) begin
      r_index <= '0;
    end else if (w_take) begin
      r_index <= r_index + 1'b1;
    end
  end

  // Completed-block counter, bumped on the DONE cycle; wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_block_count <= '0;
    end else if (r_state == DONE) begin
      r_block_count <= r_block_count + 32'd1;
    end
  end

  assign block_count = r_block_count;

endmodule

// File: doc/ksg_serializer.md
# ksg_serializer

Output-side partner of the ChaCha key stream generator. The block accepts one 512-bit keystream block over a valid/ready handshake and emits it as sixteen 32-bit words, word 0 first, over a second valid/ready handshake. It pulses `done_out` when the last word has been taken, which tells the generator that its output buffer may be reused. It also keeps a running count of completed blocks.

## Interface
Parameters:
- `WORD_SIZE`, 32, output word width in bits.
- `BLOCK_BITS`, 512, keystream block width. Must be a multiple of `WORD_SIZE`. `NUM_WORDS = BLOCK_BITS / WORD_SIZE`.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `key_in`  in  `BLOCK_BITS`  keystream block; word k is `key_in[WORD_SIZE*k +: WORD_SIZE]`.
- `valid_in`  in  1  `key_in` is valid.
- `ready_in`  out  1  block accepted on the edge where `valid_in && ready_in`.
- `data_out`  out  `WORD_SIZE`  current output word.
- `valid_out`  out  1  `data_out` is valid.
- `ready_out`  in  1  consumer takes `data_out` on the edge where `valid_out && ready_out`.
- `done_out`  out  1  one-cycle pulse after the final word handshake.
- `block_count`  out  32  number of blocks fully emitted since reset; wraps.

## Operation
- The state machine has three states: IDLE, SEND and DONE.
- **IDLE:**
  - `ready_in=1`, `valid_out=0`.
  - On an input handshake: load `key_in` into a shift register, clear the word index to 0, go to SEND.
- **SEND:**
  - `ready_in=0`, `valid_out=1`, `data_out = shreg[WORD_SIZE-1:0]`.
  - On an output handshake: shift the register right by `WORD_SIZE` and increment the index.
  - If the index was `NUM_WORDS-1`: go to DONE instead of shifting further.
- **DONE:**
  - `done_out=1`, `ready_in=0`, `valid_out=0`.
  - `block_count` increments (modulo 2^32).
  - Unconditional return to IDLE on the next edge.
- `valid_in` outside IDLE is ignored. The generator must hold the block until `ready_in`.
- `data_out` and `valid_out` must not change while `valid_out && !ready_out`. This is the stall case.
- Word order follows the generator's little-endian state layout: word 0 = `key_in[31:0]`, word 15 = `key_in[511:480]`. No byte swapping.
- **Reset mid-operation:**
  - The block is discarded immediately and the state goes to IDLE.
  - `done_out` is not asserted and `block_count` is not incremented for the aborted block.

## Timing
- **Reset values:**
  - `ready_in=1`, `valid_out=0`, `data_out=0`, `done_out=0`, `block_count=0`.
  - Shift register and index cleared to 0.
- **Latency:**
  - Block accepted at edge N; word 0 is valid in the cycle after edge N.
  - With `ready_out` held at 1, word k is taken at edge N+1+k and word 15 at N+16.
  - `done_out` is high during cycle N+16..N+17.
  - `ready_in` rises at N+17.
- Minimum block period: 18 cycles.
- `done_out` is always exactly one cycle wide and never coincides with `valid_out=1`.
- `block_count` wraps from 0xFFFFFFFF to 0 at the DONE transition.

## Configuration
- Macro `KSG_SERIALIZER_XOR_EN`.
- **Defined:**
  - Adds ports `pt_in` (in, `WORD_SIZE`), `pt_valid` (in, 1) and `pt_ready` (out, 1).
  - In SEND: `valid_out = pt_valid`, `pt_ready = ready_out`, `data_out = shreg[WORD_SIZE-1:0] ^ pt_in`.
  - A word advances only when `pt_valid && ready_out`; the plaintext and ciphertext handshakes occur on the same edge.
  - Outside SEND: `pt_ready=0`.
  - `pt_valid` reaching `valid_out` through a combinational path is accepted.
- **Undefined:** these ports do not exist and the output is raw keystream.

## Structure
- Shared package `ksg_pkg`:
  - `WORD_SIZE` and `BLOCK_BITS` defaults, and `NUM_WORDS`.
  - The serializer state enum (IDLE, SEND, DONE), also used by the bench.
- Sub-module `ser_shift_reg`: parallel load plus shift-right-by-`WORD_SIZE`, with `load` and `shift` enables. The FSM, index counter and block counter stay in `ksg_serializer`.

## Test plan
- **Basic block:** load block with word k = 0x0000_0100+k, `ready_out=1` constantly. Required:
  - words 0x100..0x10F in order on consecutive cycles;
  - `done_out` for one cycle after the last word;
  - `block_count=1`.
- **Backpressure:** same block, `ready_out` toggled 1,0,0,1 repeatedly. Required:
  - `data_out` and `valid_out` stable during stalls;
  - no word skipped or duplicated.
- **Back-to-back:** `valid_in` held high with two different blocks. Required:
  - second block accepted exactly on the cycle after `done_out`;
  - 32 correct words in total;
  - `block_count=2`.
- **Reset mid-block:** drop `reset_n` after word 7. Required:
  - immediate `valid_out=0` and `ready_in=1`;
  - no `done_out`;
  - `block_count` unchanged at 0;
  - next block emits from word 0.
- **Counter wrap:** force `block_count` to 0xFFFFFFFF and complete one block. Required: reads 0.
- **XOR build (`KSG_SERIALIZER_XOR_EN`):** `pt_in` = 0xFFFF_FFFF, `pt_valid` gaps inserted. Required:
  - `data_out = ~keyword`;
  - no advance while `pt_valid=0`.
